// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-cache main-memory arbiter.
package mem_bus_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
        owner_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker. With MEM_BUS_ARBITER_WB_PRIO_EN defined,
// a lone write-back beats a read when both caches request.
module rr_pick2
    import mem_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] we,
    input  logic               ptr,
    output logic               winner,
    output logic               valid
);

`ifndef MEM_BUS_ARBITER_WB_PRIO_EN
    logic unused_we_s;
    assign unused_we_s = ^we;
`endif

    // Winner selection: lone requester wins outright, contention resolved by pointer
    always_comb begin
        winner = 1'b0;
        valid  = 1'b0;
        case (req)
            2'b01: begin
                winner = 1'b0;
                valid  = 1'b1;
            end
            2'b10: begin
                winner = 1'b1;
                valid  = 1'b1;
            end
            2'b11: begin
                valid = 1'b1;
`ifdef MEM_BUS_ARBITER_WB_PRIO_EN
                if (we[0] != we[1]) begin
                    winner = we[1];
                end else begin
                    winner = ptr;
                end
`else
                winner = ptr;
`endif
            end
            default: begin
                winner = 1'b0;
                valid  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-cache arbiter for a single-port main memory with fixed latency.
// Optional write-back priority is enabled by defining MEM_BUS_ARBITER_WB_PRIO_EN.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = 2
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [DATA_W-1:0]              rdata,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    output logic                           busy
);

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_LAT - 1);

    arb_state_e          state_r, state_s;
    logic                ptr_r, ptr_s;
    logic [2:0]          cnt_r, cnt_s;
    logic                owner_r, owner_s;
    logic                lat_we_r, lat_we_s;
    logic [NUM_REQ-1:0]  gnt_r, gnt_s;
    logic [NUM_REQ-1:0]  done_r, done_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                mem_en_r, mem_en_s;
    logic                mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic                busy_r, busy_s;
    logic                pick_winner_s;
    logic                pick_valid_s;

    rr_pick2 u_pick (
        .req    (req),
        .we     (we),
        .ptr    (ptr_r),
        .winner (pick_winner_s),
        .valid  (pick_valid_s)
    );

    // Next-state and next-output decode; the ACCESS-cycle output registers act as the request latch
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        cnt_s       = cnt_r;
        owner_s     = owner_r;
        lat_we_s    = lat_we_r;
        gnt_s       = 2'b00;
        done_s      = 2'b00;
        rdata_s     = rdata_r;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = '0;
        mem_wdata_s = '0;
        busy_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_valid_s) begin
                    state_s     = ACCESS;
                    owner_s     = pick_winner_s;
                    ptr_s       = ~pick_winner_s;
                    lat_we_s    = we[pick_winner_s];
                    gnt_s       = owner_onehot(pick_winner_s);
                    mem_en_s    = 1'b1;
                    mem_we_s    = we[pick_winner_s];
                    mem_addr_s  = addr[pick_winner_s];
                    mem_wdata_s = wdata[pick_winner_s];
                    busy_s      = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                state_s = WAIT;
                cnt_s   = WAIT_LOAD;
                gnt_s   = owner_onehot(owner_r);
                busy_s  = 1'b1;
            end
            WAIT: begin
                gnt_s  = owner_onehot(owner_r);
                busy_s = 1'b1;
                if (cnt_r == 3'd0) begin
                    state_s = DONE;
                    done_s  = owner_onehot(owner_r);
                    if (!lat_we_r) begin
                        rdata_s = mem_rdata;
                    end else begin
                        rdata_s = rdata_r;
                    end
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            ptr_r       <= 1'b0;
            cnt_r       <= 3'd0;
            owner_r     <= 1'b0;
            lat_we_r    <= 1'b0;
            gnt_r       <= 2'b00;
            done_r      <= 2'b00;
            rdata_r     <= '0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            cnt_r       <= cnt_s;
            owner_r     <= owner_s;
            lat_we_r    <= lat_we_s;
            gnt_r       <= gnt_s;
            done_r      <= done_s;
            rdata_r     <= rdata_s;
            mem_en_r    <= mem_en_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            busy_r      <= busy_s;
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign rdata     = rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: three arbiters (MEM_LAT 2, 1, 7) each with a fixed-latency memory model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

    localparam int NI = 3;

    typedef struct {
        int          inst;
        int          owner;
        bit          w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] rd;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic [1:0]       req_a       [NI];
    logic [1:0]       we_a        [NI];
    logic [1:0][3:0]  addr_a      [NI];
    logic [1:0][31:0] wdata_a     [NI];
    logic [1:0]       gnt_a       [NI];
    logic [1:0]       done_a      [NI];
    logic [31:0]      rdata_a     [NI];
    logic             mem_en_a    [NI];
    logic             mem_we_a    [NI];
    logic [3:0]       mem_addr_a  [NI];
    logic [31:0]      mem_wdata_a [NI];
    logic [31:0]      mem_rdata_a [NI];
    logic             busy_a      [NI];

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   rst_chk_seq  = 0;
    int   rst_chk_seen = 0;

    int          en_cnt    [NI];
    int          en_cyc    [NI];
    logic        cap_we    [NI];
    logic [3:0]  cap_addr  [NI];
    logic [31:0] cap_wdata [NI];

    function automatic int lat_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 3) return 32'hDEADBEEF;
        return 32'h11111111 * 32'(i);
    endfunction

    function automatic logic [1:0] oh(input int c);
        return (c == 1) ? 2'b10 : 2'b01;
    endfunction

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
        logic [31:0] mem [16];
        logic [31:0] rd_val;
        int          rd_cnt;

        // memory returns read data only in the cycle exactly LAT after the strobe
        always @(posedge clk) begin
            if (!rst) begin
                for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
                rd_cnt <= 0;
                rd_val <= 32'h0;
            end else begin
                if (mem_en_a[g] && mem_we_a[g]) mem[mem_addr_a[g]] <= mem_wdata_a[g];
                if (mem_en_a[g] && !mem_we_a[g]) begin
                    rd_val <= mem[mem_addr_a[g]];
                    rd_cnt <= LAT;
                end else if (rd_cnt > 0) begin
                    rd_cnt <= rd_cnt - 1;
                end
            end
        end
        assign mem_rdata_a[g] = (rd_cnt == 1) ? rd_val : 32'hBAD0BAD0;

        mem_bus_arbiter #(.ADDR_W(4), .DATA_W(32), .MEM_LAT(LAT)) dut (
            .clk       (clk),
            .reset     (rst),
            .req       (req_a[g]),
            .we        (we_a[g]),
            .addr      (addr_a[g]),
            .wdata     (wdata_a[g]),
            .gnt       (gnt_a[g]),
            .done      (done_a[g]),
            .rdata     (rdata_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata_a[g]),
            .busy      (busy_a[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s inst%0d: got %h, required %h", name, g, act, exp_v);
        end
    endtask

    // Monitor: reset-state checks, mem strobe tracking, done scoreboard, overdue watchdog
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_chk_seq != rst_chk_seen) begin
                rst_chk_seen = rst_chk_seq;
                for (int g = 0; g < NI; g++) begin
                    chk("reset_ctrl", g, {25'd0, gnt_a[g], done_a[g], mem_en_a[g], mem_we_a[g], busy_a[g]}, 32'd0);
                    chk("reset_rdata", g, rdata_a[g], 32'd0);
                    chk("reset_mem_addr", g, {28'd0, mem_addr_a[g]}, 32'd0);
                    chk("reset_mem_wdata", g, mem_wdata_a[g], 32'd0);
                end
            end
            for (int g = 0; g < NI; g++) begin
                if (!rst) begin
                    en_cnt[g] = 0;
                end else if (mem_en_a[g] === 1'b1) begin
                    en_cnt[g]++;
                    en_cyc[g]    = cyc;
                    cap_we[g]    = mem_we_a[g];
                    cap_addr[g]  = mem_addr_a[g];
                    cap_wdata[g] = mem_wdata_a[g];
                end
                if (done_a[g] !== 2'b00) begin
                    if (exp_q.size() == 0 || exp_q[0].inst != g) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done inst%0d: done=%b at cycle %0d, required 00", g, done_a[g], cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", g, 32'(cyc), 32'(e.cyc));
                        chk("done_owner", g, {30'd0, done_a[g]}, {30'd0, oh(e.owner)});
                        chk("gnt", g, {30'd0, gnt_a[g]}, {30'd0, oh(e.owner)});
                        chk("busy", g, {31'd0, busy_a[g]}, 32'd1);
                        chk("rdata", g, rdata_a[g], e.rd);
                        chk("mem_en_count", g, 32'(en_cnt[g]), 32'd1);
                        chk("mem_en_cycle", g, 32'(en_cyc[g]), 32'(e.cyc - lat_of(g) - 1));
                        chk("mem_we", g, {31'd0, cap_we[g]}, {31'd0, e.w});
                        chk("mem_addr", g, {28'd0, cap_addr[g]}, {28'd0, e.a});
                        if (e.w) chk("mem_wdata", g, cap_wdata[g], e.d);
                        en_cnt[g] = 0;
                    end
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL overdue_done inst%0d: no done[%0d] by cycle %0d, required at cycle %0d",
                         exp_q[0].inst, exp_q[0].owner, cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input int g, input int c, input bit w, input logic [3:0] a, input logic [31:0] d);
        req_a[g][c]   = 1'b1;
        we_a[g][c]    = w;
        addr_a[g][c]  = a;
        wdata_a[g][c] = d;
    endtask

    task automatic expect_done(input int g, input int c, input bit w, input logic [3:0] a,
                               input logic [31:0] d, input logic [31:0] rd, input int at);
        exp_q.push_back('{g, c, w, a, d, rd, at});
    endtask

    // requester side: hold req until done is seen, drop it on the edge ending DONE
    task automatic wait_done(input int g, input int c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_a[g][c] !== 1'b1 && n < 40);
        @(posedge clk);
        #1;
        req_a[g][c] = 1'b0;
    endtask

    task automatic do_reset(input bit clr);
        rst = 1'b0;
        if (clr) begin
            for (int g = 0; g < NI; g++) begin
                req_a[g] = 2'b00; we_a[g] = 2'b00; addr_a[g] = '0; wdata_a[g] = '0;
            end
        end
        #1;
        rst_chk_seq++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int c;
        #1;
        do_reset(1'b1);

        // single read of the preloaded word
        c = cyc;
        issue(0, 0, 1'b0, 4'h3, 32'h0);
        expect_done(0, 0, 1'b0, 4'h3, 32'h0, 32'hDEADBEEF, c + 4);
        tick(2);
        addr_a[0][0] = 4'hF; we_a[0][0] = 1'b1; wdata_a[0][0] = 32'hFFFFFFFF;
        wait_done(0, 0);

        // simultaneous reads straight after reset: cache0 first
        do_reset(1'b1);
        c = cyc;
        issue(0, 0, 1'b0, 4'h1, 32'h0);
        issue(0, 1, 1'b0, 4'h2, 32'h0);
        expect_done(0, 0, 1'b0, 4'h1, 32'h0, 32'h11111111, c + 4);
        expect_done(0, 1, 1'b0, 4'h2, 32'h0, 32'h22222222, c + 9);
        fork
            wait_done(0, 0);
            wait_done(0, 1);
        join

        // read vs write-back contention (pointer back at cache0)
        c = cyc;
        issue(0, 0, 1'b0, 4'h6, 32'h0);
        issue(0, 1, 1'b1, 4'h5, 32'h12345678);
`ifdef MEM_BUS_ARBITER_WB_PRIO_EN
        expect_done(0, 1, 1'b1, 4'h5, 32'h12345678, 32'h22222222, c + 4);
        expect_done(0, 0, 1'b0, 4'h6, 32'h0, 32'h66666666, c + 9);
`else
        expect_done(0, 0, 1'b0, 4'h6, 32'h0, 32'h66666666, c + 4);
        expect_done(0, 1, 1'b1, 4'h5, 32'h12345678, 32'h66666666, c + 9);
`endif
        fork
            wait_done(0, 0);
            wait_done(0, 1);
        join

        // alternation: cache1 re-requests back to back, cache0 keeps asking
        c = cyc;
        issue(0, 1, 1'b0, 4'h7, 32'h0);
        expect_done(0, 1, 1'b0, 4'h7, 32'h0, 32'h77777777, c + 4);
        tick(1);
        issue(0, 0, 1'b0, 4'h8, 32'h0);
        expect_done(0, 0, 1'b0, 4'h8, 32'h0, 32'h88888888, c + 9);
        wait_done(0, 1);
        issue(0, 1, 1'b0, 4'h9, 32'h0);
        expect_done(0, 1, 1'b0, 4'h9, 32'h0, 32'h99999999, c + 14);
        wait_done(0, 0);
        issue(0, 0, 1'b0, 4'hA, 32'h0);
        expect_done(0, 0, 1'b0, 4'hA, 32'h0, 32'hAAAAAAAA, c + 19);
        wait_done(0, 1);
        issue(0, 1, 1'b0, 4'hB, 32'h0);
        expect_done(0, 1, 1'b0, 4'hB, 32'h0, 32'hBBBBBBBB, c + 24);
        wait_done(0, 0);
        wait_done(0, 1);

        // reset in the second WAIT cycle aborts; pending requests re-arbitrate afterwards
        c = cyc;
        issue(0, 0, 1'b0, 4'h2, 32'h0);
        tick(1);
        issue(0, 1, 1'b0, 4'h1, 32'h0);
        tick(2);
        do_reset(1'b0);
        c = cyc;
        expect_done(0, 0, 1'b0, 4'h2, 32'h0, 32'h22222222, c + 4);
        expect_done(0, 1, 1'b0, 4'h1, 32'h0, 32'h11111111, c + 9);
        fork
            wait_done(0, 0);
            wait_done(0, 1);
        join

        // latency extremes
        c = cyc;
        issue(1, 0, 1'b0, 4'h4, 32'h0);
        expect_done(1, 0, 1'b0, 4'h4, 32'h0, 32'h44444444, c + 3);
        wait_done(1, 0);
        c = cyc;
        issue(2, 1, 1'b1, 4'h4, 32'hA5A5A5A5);
        expect_done(2, 1, 1'b1, 4'h4, 32'hA5A5A5A5, 32'h0, c + 9);
        wait_done(2, 1);
        c = cyc;
        issue(2, 0, 1'b0, 4'h4, 32'h0);
        expect_done(2, 0, 1'b0, 4'h4, 32'h0, 32'hA5A5A5A5, c + 9);
        wait_done(2, 0);

        tick(12);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, is the word address width of main memory.
REQ-002 Parameter DATA_W, default 32, is the data width.
REQ-003 Parameter MEM_LAT, default 2, range 1..7, is the main-memory read/write latency in cycles after the access cycle.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  [1:0]  per-cache memory request, held high until done.
REQ-007 we  input  [1:0]  per-cache write-back flag (1 = write, 0 = read), stable while req is high.
REQ-008 addr  input  [1:0][ADDR_W-1:0]  per-cache address, stable while req is high.
REQ-009 wdata  input  [1:0][DATA_W-1:0]  per-cache write data, stable while req is high.
REQ-010 gnt  output  [1:0]  one-hot owner of the memory, high from ACCESS through DONE.
REQ-011 done  output  [1:0]  one-cycle completion pulse to the owner.
REQ-012 rdata  output  DATA_W  read data, valid while done is high for a read.
REQ-013 mem_en, mem_we  output  1 each  single-port memory strobe and write enable.
REQ-014 mem_addr, mem_wdata  output  ADDR_W, DATA_W  single-port memory address and write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS, WAIT, DONE, with all outputs registered.
REQ-018 IDLE: when any req is high, pick a winner, latch its index, we, addr and wdata, then go to ACCESS; otherwise stay in IDLE.
REQ-019 ACCESS: lasts 1 cycle with mem_en=1, mem_we, mem_addr and mem_wdata driven from the latched values, and gnt set; then go to WAIT.
REQ-020 WAIT: lasts exactly MEM_LAT cycles, counted by a 3-bit down-counter; on the last WAIT cycle, capture mem_rdata into rdata if the access is a read; then go to DONE.
REQ-021 DONE: lasts 1 cycle with done[owner]=1; then go to IDLE and clear gnt.
REQ-022 Latency: a req first seen in IDLE at cycle 0 produces done at cycle MEM_LAT+2, for reads and writes alike.
REQ-023 The requester drops req on the edge that ends DONE, so the completed request is never re-arbitrated.
REQ-024 A req that rises while another access is in progress waits, and is arbitrated in the next IDLE cycle.
REQ-025 Round-robin: a 1-bit pointer names the preferred requester; after each grant, the pointer moves to the non-winner.
REQ-026 Single request: that requester wins regardless of the pointer.
REQ-027 For writes, rdata holds its previous value; mem_en is low in every state except ACCESS.
REQ-028 Changes on req, we, addr or wdata after latching do not affect the access in progress.

Reset
REQ-029 While reset=0, asynchronously: state=IDLE, pointer=0 (cache 0 preferred), counter=0, and gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata and busy all 0.
REQ-030 Reset during ACCESS, WAIT or DONE aborts the access with no done pulse; after reset releases, the next IDLE cycle re-arbitrates.

Configuration
REQ-031 Macro MEM_BUS_ARBITER_WB_PRIO_EN defined: when both caches request and exactly one has we=1, the write-back wins regardless of the pointer, and the pointer still moves to the loser.
REQ-032 Macro not defined: pure round-robin, and we has no effect on arbitration.

Structure
REQ-033 Package mem_bus_pkg holds: the state enum (IDLE, ACCESS, WAIT, DONE), the NUM_REQ=2 constant, and the default ADDR_W and DATA_W constants; the arbiter imports it.
REQ-034 Sub-module rr_pick2: combinational 2-way picker (inputs req, we, ptr; output winner index plus a valid flag); the WB priority logic lives there under the macro.

Verification
REQ-035 Single read, cache0 addr=4'h3, mem holds 32'hDEADBEEF, MEM_LAT=2 -> mem_en at cycle 1, done[0] at cycle 4, rdata=32'hDEADBEEF.
REQ-036 Simultaneous reads from both caches after reset -> cache0 served first (done[0] at cycle 4), cache1 second (done[1] at cycle 9); the pointer ends at 0.
REQ-037 With the macro defined, cache0 read and cache1 write (addr=4'h5, wdata=32'h12345678) together -> cache1 first, mem_we=1 and mem_addr=5 in its ACCESS cycle; without the macro -> cache0 first.
REQ-038 Back-to-back requests from cache1 while cache0 keeps req high -> grants alternate 1,0,1,0 with no starvation.
REQ-039 Reset asserted in the second WAIT cycle -> all outputs 0 immediately, no done pulse; after release, a pending req is granted with done at MEM_LAT+2 cycles.
REQ-040 Sweep MEM_LAT=1 and MEM_LAT=7 -> done at cycles 3 and 9 respectively; mem_en is high for exactly one cycle per access.
